out_demux_1x2: RTL and testbench

- Write-side counterpart of the operand-B source mux: routes one DATA_WIDTH result word from the datapath to either the data memory write port or the external output port.
- Memory path is a registered single-cycle write strobe.
- External path is buffered in a DEPTH-entry FIFO, drained by the off-chip consumer with a valid/ready handshake.
- Sits between the accumulator/ALU result bus and the data memory / external output pins.

---
 rtl/datapath_pkg.sv | 11 +
 rtl/out_demux_1x2_sync_fifo.sv | 49 ++++
 rtl/out_demux_1x2.sv | 62 ++++++
 tb/tb_out_demux_1x2.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: word width, word type and destination-select codes.
package datapath_pkg;

    localparam int DATA_WIDTH = 11;

    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam logic SEL_DMEM = 1'b0;
    localparam logic SEL_EXT  = 1'b1;

endpackage : datapath_pkg

// File: rtl/out_demux_1x2_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; head word is shown directly, zero when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // The extra pointer MSB separates full from empty; the difference wraps mod 2*DEPTH.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; stale entries are masked by the empty check.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule : sync_fifo

// File: rtl/out_demux_1x2.sv
// Routes each accepted result word to the data-memory write port or the external output FIFO.
module out_demux_1x2
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    input  logic                       select_1x2,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      dm_data_out,
    output logic                       dm_write,
    output logic [DATA_WIDTH-1:0]      ext_out,
    output logic                       ext_valid,
    input  logic                       ext_ready,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push_ext;
    logic push_dmem;
    logic pop_ext;

    // A full FIFO refuses input even when a pop frees a slot this same cycle.
    assign in_ready  = (select_1x2 == SEL_DMEM) ? 1'b1 : !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push_ext  = accept && (select_1x2 == SEL_EXT);
    assign push_dmem = accept && (select_1x2 == SEL_DMEM);
    assign ext_valid = !fifo_empty;
    assign pop_ext   = ext_valid && ext_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_write    <= 1'b0;
            dm_data_out <= '0;
        end else begin
            dm_write <= push_dmem;
            if (push_dmem) dm_data_out <= in_data;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ext_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ext),
        .push_data (in_data),
        .pop       (pop_ext),
        .pop_data  (ext_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule : out_demux_1x2

// File: tb/tb_out_demux_1x2.sv
// Directed bench for out_demux_1x2: reset, memory route, external FIFO order, full, wrap.
module tb_out_demux_1x2;

    localparam int DW    = 11;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          select_1x2 = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dm_data_out;
    logic          dm_write;
    logic [DW-1:0] ext_out;
    logic          ext_valid;
    logic          ext_ready = 1'b0;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    out_demux_1x2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .select_1x2  (select_1x2),
        .in_ready    (in_ready),
        .dm_data_out (dm_data_out),
        .dm_write    (dm_write),
        .ext_out     (ext_out),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .fifo_count  (fifo_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_data = 11'd77; select_1x2 = 1'b1; in_valid = 1'b1;
        cyc();
        in_data = 11'd88; select_1x2 = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++; if (dm_write !== 1'b1 || ext_valid !== 1'b1) begin errors++;
            $display("FAIL rst_pre: dm_write=%0b ext_valid=%0b required 1 1", dm_write, ext_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL rst_dm_write: got %0b required 0", dm_write); end
        checks++; if (dm_data_out !== '0) begin errors++; $display("FAIL rst_dm_data: got %0d required 0", dm_data_out); end
        checks++; if (ext_valid !== 1'b0) begin errors++; $display("FAIL rst_ext_valid: got %0b required 0", ext_valid); end
        checks++; if (ext_out !== '0) begin errors++; $display("FAIL rst_ext_out: got %0d required 0", ext_out); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mem_route();
        in_data = 11'b11101001001; select_1x2 = 1'b0; in_valid = 1'b1; ext_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mem_in_ready: got %0b required 1", in_ready); end
        cyc();
        in_valid = 1'b0; in_data = '0;
        checks++; if (dm_write !== 1'b1 || dm_data_out !== 11'h749) begin errors++;
            $display("FAIL mem_write: dm_write=%0b data=%0h required 1 749", dm_write, dm_data_out); end
        cyc();
        checks++; if (dm_write !== 1'b0 || dm_data_out !== 11'h749) begin errors++;
            $display("FAIL mem_hold: dm_write=%0b data=%0h required 0 749", dm_write, dm_data_out); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mem_count: got %0d required 0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 11'd5; vals[1] = 11'd1023; vals[2] = 11'd2047;
        select_1x2 = 1'b0; in_valid = 1'b1;
        in_data = vals[0];
        cyc();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) in_data = vals[i];
            else in_valid = 1'b0;
            checks++; if (dm_write !== 1'b1 || dm_data_out !== vals[i-1]) begin errors++;
                $display("FAIL b2b_%0d: dm_write=%0b data=%0d required 1 %0d", i-1, dm_write, dm_data_out, vals[i-1]); end
            cyc();
        end
        checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL b2b_end: dm_write=%0b required 0", dm_write); end
    endtask

    task automatic test_ext_order();
        ext_ready = 1'b0; select_1x2 = 1'b1; in_valid = 1'b1;
        in_data = 11'b00001100100;
        cyc();
        checks++; if (ext_valid !== 1'b1 || ext_out !== 11'd100 || fifo_count !== 3'd1) begin errors++;
            $display("FAIL ext_first: valid=%0b out=%0d count=%0d required 1 100 1", ext_valid, ext_out, fifo_count); end
        in_data = 11'b00000000001;
        cyc();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2 || ext_out !== 11'd100) begin errors++;
            $display("FAIL ext_two: count=%0d out=%0d required 2 100", fifo_count, ext_out); end
        checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL ext_no_dm: dm_write=%0b required 0", dm_write); end
        ext_ready = 1'b1;
        cyc();
        checks++; if (ext_out !== 11'd1 || fifo_count !== 3'd1) begin errors++;
            $display("FAIL ext_pop1: out=%0d count=%0d required 1 1", ext_out, fifo_count); end
        cyc();
        checks++; if (ext_valid !== 1'b0 || ext_out !== '0 || fifo_count !== 3'd0) begin errors++;
            $display("FAIL ext_empty: valid=%0b out=%0d count=%0d required 0 0 0", ext_valid, ext_out, fifo_count); end
        ext_ready = 1'b0;
    endtask

    task automatic test_full();
        ext_ready = 1'b0; select_1x2 = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(10 + i);
            cyc();
        end
        in_data = 11'd99;
        #1;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b required 0", in_ready); end
        cyc();
        checks++; if (fifo_count !== 3'd4 || ext_out !== 11'd10) begin errors++;
            $display("FAIL full_reject: count=%0d out=%0d required 4 10", fifo_count, ext_out); end
        select_1x2 = 1'b0; in_data = 11'd55;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_dm_ready: got %0b required 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (dm_write !== 1'b1 || dm_data_out !== 11'd55 || fifo_count !== 3'd4) begin errors++;
            $display("FAIL full_dm_write: dm_write=%0b data=%0d count=%0d required 1 55 4", dm_write, dm_data_out, fifo_count); end
        ext_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ext_out !== DW'(10 + i)) begin errors++;
                $display("FAIL full_drain_%0d: got %0d required %0d", i, ext_out, 10 + i); end
            cyc();
        end
        checks++; if (fifo_count !== 3'd0 || ext_valid !== 1'b0) begin errors++;
            $display("FAIL full_drained: count=%0d valid=%0b required 0 0", fifo_count, ext_valid); end
        ext_ready = 1'b0;
    endtask

    task automatic test_push_pop_wrap();
        int q[$];
        ext_ready = 1'b0; select_1x2 = 1'b1; in_valid = 1'b1;
        in_data = 11'd200; cyc(); q.push_back(200);
        in_data = 11'd201; cyc(); q.push_back(201);
        ext_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_data = DW'(k);
            #1;
            checks++; if (ext_out !== DW'(q[0]) || in_ready !== 1'b1) begin errors++;
                $display("FAIL wrap_head_%0d: out=%0d ready=%0b required %0d 1", k, ext_out, in_ready, q[0]); end
            cyc();
            void'(q.pop_front());
            q.push_back(k);
            checks++; if (fifo_count !== 3'd2) begin errors++;
                $display("FAIL wrap_count_%0d: got %0d required 2", k, fifo_count); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ext_out !== DW'(q[0])) begin errors++;
                $display("FAIL wrap_tail_%0d: got %0d required %0d", i, ext_out, q[0]); end
            void'(q.pop_front());
            cyc();
        end
        checks++; if (ext_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++;
            $display("FAIL wrap_empty: valid=%0b count=%0d required 0 0", ext_valid, fifo_count); end
        ext_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        ext_ready = 1'b0; select_1x2 = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(30 + i);
            cyc();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL rf_fill: got %0d required 4", fifo_count); end
        select_1x2 = 1'b0; in_data = 11'd66;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0 || ext_valid !== 1'b0 || ext_out !== '0) begin errors++;
            $display("FAIL rf_reset: count=%0d valid=%0b out=%0d required 0 0 0", fifo_count, ext_valid, ext_out); end
        cyc();
        checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL rf_no_dm: dm_write=%0b required 0", dm_write); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        select_1x2 = 1'b1; in_valid = 1'b1; in_data = 11'b00000000111;
        cyc();
        in_valid = 1'b0;
        checks++; if (ext_out !== 11'd7 || ext_valid !== 1'b1 || fifo_count !== 3'd1) begin errors++;
            $display("FAIL rf_push: out=%0d valid=%0b count=%0d required 7 1 1", ext_out, ext_valid, fifo_count); end
        ext_ready = 1'b1;
        cyc();
        checks++; if (ext_valid !== 1'b0 || ext_out !== '0) begin errors++;
            $display("FAIL rf_stale: valid=%0b out=%0d required 0 0", ext_valid, ext_out); end
        ext_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        test_reset();
        test_mem_route();
        test_back_to_back();
        test_ext_order();
        test_full();
        test_push_pop_wrap();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_out_demux_1x2
